// File: rtl/rank_filter_ctrl.sv
// ---------------------------------------------------------------------------
// rank_filter_ctrl
//
// Sequencing controller for a 3x3 rank-order (median/min/max) filter.
// Accepts a raster pixel stream, keeps two line buffers plus a 3x3 window
// register, exposes each complete window to an external combinational
// sorter, and registers one rank of the sorted result onto a valid/ready
// output stream.
//
// Optional feature macro: RANK_FILTER_SEL_EN
//   defined   : rank_sel port exists; out_pix = rank rank_sel (9..15 -> 8),
//               sampled when the output stage loads.
//   undefined : no rank_sel port; out_pix is always rank 4 (median).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_pix     input pixel (8b)
//   in_valid   input pixel valid
//   in_sof     first pixel of a frame, sampled with in_valid
//   in_ready   controller accepts in_pix this cycle
//   win_o      window to sorter, msb first w11,w12,w13,w21,..,w33
//              (row 1 = oldest line, column 1 = oldest pixel)
//   sorted_i   sorter result, ascending, rank 0 in [71:64]
//   rank_sel   rank to output (only with RANK_FILTER_SEL_EN)
//   out_pix    filtered pixel
//   out_valid  out_pix valid
//   out_ready  downstream accepts out_pix
//   out_sof    first output of a frame (qualified by out_valid)
//   out_eol    last output of a line (qualified by out_valid)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is combinational from out_ready (through the output
// stage load term); out_valid never depends combinationally on out_ready.
// ---------------------------------------------------------------------------
module rank_filter_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_pix,
  input  logic        in_valid,
  input  logic        in_sof,
  output logic        in_ready,
  output logic [71:0] win_o,
  input  logic [71:0] sorted_i,
`ifdef RANK_FILTER_SEL_EN
  input  logic [3:0]  rank_sel,
`endif
  output logic [7:0]  out_pix,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eol
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // -------------------------------------------------------------------------
  // Position counters
  // -------------------------------------------------------------------------
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             accept;

  // An accepted in_sof pixel is frame position (0,0) whatever the counters say,
  // which lets a source resynchronise mid-frame.
  assign cur_col = in_sof ? '0 : col_q;
  assign cur_row = in_sof ? '0 : row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Line buffers: lb0 = previous line, lb1 = line before that.
  // Not reset; rows 0 and 1 of a frame never form a valid window, so stale
  // contents from an earlier frame are never presented to the sorter.
  // -------------------------------------------------------------------------
  logic [7:0] lb0_q [IMG_W];
  logic [7:0] lb1_q [IMG_W];
  logic [7:0] lb0_rd;
  logic [7:0] lb1_rd;

  assign lb0_rd = lb0_q[cur_col];
  assign lb1_rd = lb1_q[cur_col];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[cur_col] <= lb0_rd;
      lb0_q[cur_col] <= in_pix;
    end
  end

  // -------------------------------------------------------------------------
  // Window registers, one 24-bit word per row {c1,c2,c3}; shifting left
  // drops the oldest column and appends the new right column.
  // -------------------------------------------------------------------------
  logic [23:0] wr1_q, wr1_d;
  logic [23:0] wr2_q, wr2_d;
  logic [23:0] wr3_q, wr3_d;
  logic        win_valid_q, win_valid_d;
  logic        win_sof_q, win_sof_d;
  logic        win_eol_q, win_eol_d;
  logic        load;

  always_comb begin
    wr1_d       = wr1_q;
    wr2_d       = wr2_q;
    wr3_d       = wr3_q;
    win_valid_d = win_valid_q;
    win_sof_d   = win_sof_q;
    win_eol_d   = win_eol_q;
    if (accept) begin
      wr1_d       = {wr1_q[15:0], lb1_rd};
      wr2_d       = {wr2_q[15:0], lb0_rd};
      wr3_d       = {wr3_q[15:0], in_pix};
      win_valid_d = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      win_sof_d   = (cur_row == ROW_TWO) && (cur_col == COL_TWO);
      win_eol_d   = (cur_col == COL_LAST);
    end else if (load) begin
      // An accept in the same cycle as a load already replaces the window,
      // so clearing only applies when no new pixel arrives.
      win_valid_d = 1'b0;
    end
  end

  assign win_o = {wr1_q, wr2_q, wr3_q};

  // -------------------------------------------------------------------------
  // Handshake glue
  // -------------------------------------------------------------------------
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_pix_q, out_pix_d;
  logic       out_sof_q, out_sof_d;
  logic       out_eol_q, out_eol_d;

  assign load     = win_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !win_valid_q || load;
  assign accept   = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Rank selection from the sorter result
  // -------------------------------------------------------------------------
  logic [3:0] rank_idx;
  logic [7:0] sel_pix;

`ifdef RANK_FILTER_SEL_EN
  assign rank_idx = (rank_sel > 4'd8) ? 4'd8 : rank_sel;
`else
  assign rank_idx = 4'd4;
`endif

  always_comb begin
    sel_pix = '0;
    for (int k = 0; k < 9; k++) begin
      if (rank_idx == 4'(k)) begin
        sel_pix = sorted_i[71 - 8*k -: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_pix_d   = sel_pix;
      out_sof_d   = win_sof_q;
      out_eol_d   = win_eol_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      wr1_q       <= '0;
      wr2_q       <= '0;
      wr3_q       <= '0;
      win_valid_q <= 1'b0;
      win_sof_q   <= 1'b0;
      win_eol_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      wr1_q       <= wr1_d;
      wr2_q       <= wr2_d;
      wr3_q       <= wr3_d;
      win_valid_q <= win_valid_d;
      win_sof_q   <= win_sof_d;
      win_eol_q   <= win_eol_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
    end
  end

endmodule

// File: tb/tb_rank_filter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rank_filter_ctrl
//
// Bench for rank_filter_ctrl at IMG_W=5, IMG_H=5. The external sorter is a
// behavioural sort of win_o. The reference model works on whole frames held
// in a 2-D array: for every interior pixel it takes the 3x3 neighbourhood,
// sorts it and picks the requested rank; results are pushed into exp_q with
// their sof/eol tags and popped by an independent output monitor.
// ---------------------------------------------------------------------------
module tb_rank_filter_ctrl;

  localparam int W = 5;
  localparam int H = 5;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [7:0]  in_pix;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic [71:0] win_o;
  logic [71:0] sorted;
  logic [7:0]  out_pix;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
`ifdef RANK_FILTER_SEL_EN
  logic [3:0]  rank_sel;
`endif

  rank_filter_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pix    (in_pix),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .win_o     (win_o),
    .sorted_i  (sorted),
`ifdef RANK_FILTER_SEL_EN
    .rank_sel  (rank_sel),
`endif
    .out_pix   (out_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  // ---------------- bookkeeping ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] exp_q[$];
  logic [7:0] frm [H][W];
  int         cur_rank = 4;
  int         out_mode = 0;   // 0: ready high, 1: random, 2: ready low
  bit         mon_en   = 1'b1;
  int         out_cnt  = 0;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- external sorter + reference helpers ----------------
  function automatic logic [71:0] sort9(input logic [71:0] v);
    logic [7:0] a [9];
    logic [7:0] t;
    logic [71:0] r;
    for (int i = 0; i < 9; i++) a[i] = v[71 - 8*i -: 8];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < 9; i++) r[71 - 8*i -: 8] = a[i];
    return r;
  endfunction

  always_comb sorted = sort9(win_o);

  // Neighbourhood of frame pixel (r,c) as the bottom-right corner.
  function automatic logic [71:0] exp_window(input int r, input int c);
    return {frm[r-2][c-2], frm[r-2][c-1], frm[r-2][c],
            frm[r-1][c-2], frm[r-1][c-1], frm[r-1][c],
            frm[r][c-2],   frm[r][c-1],   frm[r][c]};
  endfunction

  task automatic push_expect();
    int rk;
    logic [71:0] s;
    rk = (cur_rank > 8) ? 8 : cur_rank;
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        s = sort9(exp_window(r, c));
        exp_q.push_back({(r == 2 && c == 2), (c == W - 1), s[71 - 8*rk -: 8]});
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frm[r][c] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- output ready generator ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] pix, input logic sof);
    bit ok;
    in_pix   = pix;
    in_sof   = sof;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout got 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Sends the first npix pixels of frm in raster order; checks win_o right
  // after each accept that completes a window.
  task automatic send_frame(input int npix, input bit gaps);
    int r, c;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / W;
      c = idx % W;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      send(frm[r][c], idx == 0);
      if (r >= 2 && c >= 2) check("window", win_o, exp_window(r, c));
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300; t++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_queue_size", 72'(exp_q.size()), 72'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [9:0] pw = '0;
  logic [9:0] e;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (pv && !pr) begin
        check("hold_valid", 72'(out_valid), 72'd1);
        check("hold_data", 72'({out_sof, out_eol, out_pix}), 72'(pw));
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output got %h expected none at %0t",
                   {out_sof, out_eol, out_pix}, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 72'({out_sof, out_eol, out_pix}), 72'(e));
        end
      end
    end
    pv = out_valid;
    pr = out_ready;
    pw = {out_sof, out_eol, out_pix};
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int base;

  initial begin
    rst_n    = 1'b0;
    in_pix   = '0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
`ifdef RANK_FILTER_SEL_EN
    rank_sel = 4'd4;
`endif
    #12;
    check("rst_out_valid", 72'(out_valid), 72'd0);
    check("rst_out_pix", 72'(out_pix), 72'd0);
    check("rst_out_sof", 72'(out_sof), 72'd0);
    check("rst_out_eol", 72'(out_eol), 72'd0);
    check("rst_in_ready", 72'(in_ready), 72'd1);
    check("rst_win", win_o, 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Raster ramp: medians equal the centre pixel.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frm[r][c] = 8'(r * W + c);
    push_expect();
    send_frame(W * H, 1'b0);
    wait_drain();

    // All 0xFF except one dark pixel inside the first window.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frm[r][c] = 8'hFF;
    frm[1][1] = 8'h00;
    push_expect();
    send_frame(W * H, 1'b0);
    wait_drain();
`ifdef RANK_FILTER_SEL_EN
    foreach (frm[r, c]) frm[r][c] = 8'($urandom_range(0, 255));
    frm[1][1] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      cur_rank = (k == 0) ? 0 : (k == 1) ? 8 : 12;
      rank_sel = 4'(cur_rank);
      push_expect();
      send_frame(W * H, 1'b0);
      wait_drain();
    end
    cur_rank = 4;
    rank_sel = 4'd4;
`endif

    // Downstream stall mid-stream.
    fill_random();
    push_expect();
    fork
      send_frame(W * H, 1'b0);
      begin
        repeat (14) @(posedge clk);
        out_mode = 2;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 72'(in_ready), 72'd0);
        check("stall_out_valid", 72'(out_valid), 72'd1);
        out_mode = 0;
      end
    join
    wait_drain();

    // in_sof at pixel 7 restarts the frame.
    fill_random();
    for (int idx = 0; idx < 7; idx++) send(frm[idx / W][idx % W], idx == 0);
    fill_random();
    push_expect();
    send_frame(W * H, 1'b0);
    wait_drain();

    // Asynchronous reset mid-frame.
    mon_en = 1'b0;
    fill_random();
    for (int idx = 0; idx < 17; idx++) send(frm[idx / W][idx % W], idx == 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 72'(out_valid), 72'd0);
    check("midrst_out_pix", 72'(out_pix), 72'd0);
    check("midrst_out_sof", 72'(out_sof), 72'd0);
    check("midrst_out_eol", 72'(out_eol), 72'd0);
    check("midrst_in_ready", 72'(in_ready), 72'd1);
    check("midrst_win", win_o, 72'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    base = out_cnt;
    fill_random();
    push_expect();
    send_frame(W * H, 1'b0);
    wait_drain();
    check("post_reset_count", 72'(out_cnt - base), 72'd9);

    // Random traffic, 20 frames.
    out_mode = 1;
    base = out_cnt;
    for (int f = 0; f < 20; f++) begin
      fill_random();
      push_expect();
      send_frame(W * H, 1'b1);
    end
    out_mode = 0;
    wait_drain();
    check("random_count", 72'(out_cnt - base), 72'd180);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
